inout_sched: RTL

- Round-robin scheduler that merges three requesters with different handshake protocols onto one rdy/vld output stream.
- Requester A uses rdy/vld, requester B uses req/ack, and requester D uses pop/ack, where the scheduler pops and the source acks with data.
- It sits in front of the inAndOut datapath, sequencing which source owns the shared output beat.
- Each output beat carries a 2-bit source tag.

---
 rtl/inout_sched_if.sv | 29 ++
 rtl/inout_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/inout_sched_if.sv
// Bundle of the three requester channels (A rdy/vld, B req/ack, D pop/ack)
// and the merged rdy/vld output stream of the inout_sched scheduler.
// The master modport is the scheduler side; slave is the sources/sink side.
interface inout_sched_if #(parameter int DW = 32);
  logic          a_vld;
  logic [DW-1:0] a_data;
  logic          a_rdy;
  logic          b_req;
  logic [DW-1:0] b_data;
  logic          b_ack;
  logic          d_avail;
  logic          d_pop;
  logic          d_ack;
  logic [DW-1:0] d_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;

  modport master (
    input  a_vld, a_data, b_req, b_data, d_avail, d_ack, d_data, out_rdy,
    output a_rdy, b_ack, d_pop, out_vld, out_data, out_src
  );

  modport slave (
    output a_vld, a_data, b_req, b_data, d_avail, d_ack, d_data, out_rdy,
    input  a_rdy, b_ack, d_pop, out_vld, out_data, out_src
  );
endinterface

// File: rtl/inout_sched.sv
// inout_sched: round-robin scheduler merging requester A (rdy/vld),
// requester B (req/ack) and requester D (pop/ack) onto one rdy/vld output
// beat tagged with its source (0=A, 1=B, 2=D). One beat every two cycles
// at best: a grant cycle in IDLE followed by the HOLD beat.
// Optional per-source grant counters are built when INOUT_SCHED_STATS_EN
// is defined (adds stats_clr, cnt_a, cnt_b, cnt_d).
module inout_sched #(
  parameter int DW = 32
) (
  input  logic clk,
  input  logic rst_n,
  inout_sched_if.master bus
`ifdef INOUT_SCHED_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] cnt_a,
  output logic [15:0] cnt_b,
  output logic [15:0] cnt_d
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_D = 2'd2;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic          b_mask_q;
  logic          b_ack_q;
  logic          d_pop_q;
  logic          out_vld_q;
  logic [DW-1:0] out_data_q;
  logic [1:0]    out_src_q;

  logic          e_a, e_b, e_d;
  logic          grant;
  logic [1:0]    winner;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    case (s)
      SRC_A:   return SRC_B;
      SRC_B:   return SRC_D;
      default: return SRC_A;
    endcase
  endfunction

  // Eligibility (IDLE only) and rotating-priority winner starting at ptr
  always_comb begin
    e_a    = (state_q == IDLE) & bus.a_vld;
    e_b    = (state_q == IDLE) & bus.b_req & ~b_mask_q;
    e_d    = (state_q == IDLE) & bus.d_avail;
    grant  = 1'b1;
    winner = ptr_q;
    case (ptr_q)
      SRC_B: begin
        if (e_b)      winner = SRC_B;
        else if (e_d) winner = SRC_D;
        else if (e_a) winner = SRC_A;
        else          grant  = 1'b0;
      end
      SRC_D: begin
        if (e_d)      winner = SRC_D;
        else if (e_a) winner = SRC_A;
        else if (e_b) winner = SRC_B;
        else          grant  = 1'b0;
      end
      default: begin
        if (e_a)      winner = SRC_A;
        else if (e_b) winner = SRC_B;
        else if (e_d) winner = SRC_D;
        else          grant  = 1'b0;
      end
    endcase
  end

  // A is accepted in the grant cycle itself, so its ready is combinational
  assign bus.a_rdy    = grant & (winner == SRC_A);
  assign bus.b_ack    = b_ack_q;
  assign bus.d_pop    = d_pop_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_src  = out_src_q;

  // Scheduler FSM: grant in IDLE, wait for D data in FETCH, present beat in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= SRC_A;
      b_mask_q   <= 1'b0;
      b_ack_q    <= 1'b0;
      d_pop_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= SRC_A;
    end else begin
      // b_ack, d_pop and the B mask are single-cycle pulses
      b_ack_q  <= 1'b0;
      d_pop_q  <= 1'b0;
      b_mask_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            ptr_q <= next_src(winner);
            case (winner)
              SRC_A: begin
                out_data_q <= bus.a_data;
                out_src_q  <= SRC_A;
                out_vld_q  <= 1'b1;
                state_q    <= HOLD;
              end
              SRC_B: begin
                out_data_q <= bus.b_data;
                out_src_q  <= SRC_B;
                out_vld_q  <= 1'b1;
                b_ack_q    <= 1'b1;
                b_mask_q   <= 1'b1;
                state_q    <= HOLD;
              end
              default: begin
                d_pop_q <= 1'b1;
                state_q <= FETCH;
              end
            endcase
          end
        end
        FETCH: begin
          // No timeout and no abort on d_avail dropping: the pop is owed data
          if (bus.d_ack) begin
            out_data_q <= bus.d_data;
            out_src_q  <= SRC_D;
            out_vld_q  <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef INOUT_SCHED_STATS_EN
  logic [15:0] cnt_a_q, cnt_b_q, cnt_d_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Per-source grant counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_d_q <= '0;
    end else if (stats_clr) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_d_q <= '0;
    end else if (grant) begin
      case (winner)
        SRC_A:   cnt_a_q <= sat_inc(cnt_a_q);
        SRC_B:   cnt_b_q <= sat_inc(cnt_b_q);
        default: cnt_d_q <= sat_inc(cnt_d_q);
      endcase
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
  assign cnt_d = cnt_d_q;
`endif

endmodule
